// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, the BCD digit width and the 10^N-1 helper that
// sizes the saturation limit (used only when BIN2BCD_SAT_EN is defined).
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  // It is evaluated at elaboration time to build the saturation limit.
  function automatic logic [63:0] bcd_max_value(input int digits);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < digits; i++) begin
      acc = acc * 64'd10;
    end
    return acc - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction stage for shift-and-add-3 conversion.
// A digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Add 3 when the digit would become 10 or more after doubling.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(5)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit/clock).
// Converts a BIN_W-bit unsigned value into DIGITS packed BCD digits using a
// start/busy/done handshake. The result register only changes when a
// conversion completes or on reset, so a downstream display never sees
// intermediate values.
// Optional feature: define BIN2BCD_SAT_EN to saturate the result to all
// nines (and raise overflow) when the captured value exceeds 10^DIGITS-1.
// Without it, the result is valor_bin mod 10^DIGITS and overflow stays 0.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
)
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              valor_bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Counter value during the final shift iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_busy;
  logic               r_done;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_scratch_next;
  logic [BIN_W-1:0]   w_shift_next;
  logic               w_carry_out;
  logic               w_last;
  logic [BCD_W-1:0]   w_result;

  // Per-digit add-3 correction on the scratch register.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // {scratch, shift} shifted left by one, binary MSB entering the units digit.
  // The bit leaving the top digit is dropped from the result, which makes the
  // result valor_bin mod 10^DIGITS. It is recycled into the vacated LSB of the
  // shift register; those low bits are never read after the last iteration.
  assign {w_carry_out, w_scratch_next} = {w_adj, r_shift[BIN_W-1]};
  assign w_shift_next = {r_shift[BIN_W-2:0], w_carry_out};
  assign w_last       = (r_cnt == LAST_ITER);

`ifdef BIN2BCD_SAT_EN
  localparam logic [63:0] MAX_VAL = bcd_max_value(DIGITS);

  logic r_ovf_pend;
  logic r_ovf;

  // Saturate to all nines when the captured value did not fit.
  assign w_result = r_ovf_pend ? {DIGITS{4'h9}} : w_scratch_next;
  assign overflow = r_ovf;
`else
  assign w_result = w_scratch_next;
  assign overflow = 1'b0;
`endif

  // Control FSM: capture in IDLE, one shift-and-add-3 step per SHIFT cycle,
  // and a one-cycle DONE. The result register is loaded on the edge that
  // enters DONE so that the new value and the done pulse are both visible
  // during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef BIN2BCD_SAT_EN
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= valor_bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
`ifdef BIN2BCD_SAT_EN
            r_ovf_pend <= (64'(valor_bin) > MAX_VAL);
`endif
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= w_shift_next;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_result;
`ifdef BIN2BCD_SAT_EN
            r_ovf   <= r_ovf_pend;
`endif
          end
        end
        DONE: begin
          // start is deliberately not sampled here; it is not queued.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: idle/reset checks, cycle-exact
// handshake sequences and a table of conversion vectors. A scoreboard queue
// gets an expected result when a start is accepted and is checked on done.
// Build with +define+BIN2BCD_SAT_EN to check the saturating variant.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] valor_bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [19:0] val;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  bin2bcd_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valor_bin (valor_bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result by decimal division, independent of shift-and-add-3.
  function automatic exp_t model(input logic [19:0] v);
    exp_t e;
    int unsigned m;
    m = 32'(v);
    e.ovf = 1'b0;
`ifdef BIN2BCD_SAT_EN
    if (m > 999999) begin
      m = 999999;
      e.ovf = 1'b1;
    end
`endif
    m = m % 1000000;
    e.bcd = '0;
    for (int d = 0; d < 6; d++) begin
      e.bcd[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of a conversion; returns the cycle index of done or -1.
  task automatic wait_done(input int max_c, output int at_c);
    at_c = -1;
    for (int c = 1; c <= max_c; c++) begin
      if (done) begin
        at_c = c;
        break;
      end
      tick();
    end
  endtask

  // Scoreboard: every done pops one expected result.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra_done: got done with bcd=%h, required no done", bcd);
      end else begin
        e = sb_q.pop_front();
        $display("conv: bcd=%h overflow=%0d (expected %h/%0d)", bcd, overflow, e.bcd, e.ovf);
        chk("sb_bcd", 32'(bcd), 32'(e.bcd));
        chk("sb_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    int at_c;
    int t1;
    int t2;

    // Vector table.
    vecs[0]  = '{20'd7,       24'h000007, 1'b0};
    vecs[1]  = '{20'd9,       24'h000009, 1'b0};
    vecs[2]  = '{20'd10,      24'h000010, 1'b0};
    vecs[3]  = '{20'd99,      24'h000099, 1'b0};
    vecs[4]  = '{20'd100,     24'h000100, 1'b0};
    vecs[5]  = '{20'd4095,    24'h004095, 1'b0};
    vecs[6]  = '{20'd65535,   24'h065535, 1'b0};
    vecs[7]  = '{20'd999999,  24'h999999, 1'b0};
`ifdef BIN2BCD_SAT_EN
    vecs[8]  = '{20'd1000000, 24'h999999, 1'b1};
    vecs[9]  = '{20'd1048575, 24'h999999, 1'b1};
`else
    vecs[8]  = '{20'd1000000, 24'h000000, 1'b0};
    vecs[9]  = '{20'd1048575, 24'h048575, 1'b0};
`endif
    vecs[10] = '{20'd500000,  24'h500000, 1'b0};
    vecs[11] = '{20'd314159,  24'h314159, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    valor_bin = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("idle_bcd", 32'(bcd), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_ovf", 32'(overflow), 32'h0);
    end

    // Cycle-exact handshake for 123456.
    valor_bin = 20'd123456;
    start     = 1'b1;
    sb_q.push_back(model(20'd123456));
    tick();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("timed_busy_c%0d", c), 32'(busy), (c <= 20) ? 32'h1 : 32'h0);
      chk($sformatf("timed_done_c%0d", c), 32'(done), (c == 21) ? 32'h1 : 32'h0);
      if (c == 21) chk("timed_bcd", 32'(bcd), 32'h123456);
      if (c < 21) tick();
    end
    tick();

    // Start re-pulsed in cycle 5 with a new value: ignored.
    valor_bin = 20'd123456;
    start     = 1'b1;
    sb_q.push_back(model(20'd123456));
    tick();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 5) begin
        start     = 1'b1;
        valor_bin = 20'd42;
      end else begin
        start = 1'b0;
      end
      if (c == 21) begin
        chk("repulse_done", 32'(done), 32'h1);
        chk("repulse_bcd", 32'(bcd), 32'h123456);
      end
      if (c < 21) tick();
    end
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("repulse_no_extra_done", 32'(done), 32'h0);
    end

    // Back-to-back with start held high: 0 then 999999.
    valor_bin = 20'd0;
    start     = 1'b1;
    sb_q.push_back(model(20'd0));
    sb_q.push_back(model(20'd999999));
    tick();
    valor_bin = 20'd999999;
    t1 = -1;
    t2 = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = c;
          chk("b2b_first_bcd", 32'(bcd), 32'h000000);
        end else begin
          t2 = c;
          chk("b2b_second_bcd", 32'(bcd), 32'h999999);
          start = 1'b0;
          break;
        end
      end
      tick();
    end
    start = 1'b0;
    chk("b2b_first_done_cycle", 32'(t1), 32'd21);
    chk("b2b_done_spacing", 32'(t2 - t1), 32'd22);
    repeat (3) tick();

    // Table-driven conversions.
    for (int i = 0; i < 12; i++) begin
      valor_bin = vecs[i].val;
      start     = 1'b1;
      sb_q.push_back(model(vecs[i].val));
      tick();
      start = 1'b0;
      wait_done(30, at_c);
      chk($sformatf("vec%0d_done_cycle", i), 32'(at_c), 32'd21);
      chk($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      tick();
      chk($sformatf("vec%0d_hold", i), 32'(bcd), 32'(vecs[i].bcd));
    end

    // Reset in cycle 10 of a conversion aborts it and clears bcd.
    valor_bin = 20'd555555;
    start     = 1'b1;
    sb_q.push_back(model(20'd555555));
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    sb_q.delete();
    tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    tick();
    valor_bin = 20'd7;
    start     = 1'b1;
    sb_q.push_back(model(20'd7));
    tick();
    start = 1'b0;
    wait_done(30, at_c);
    chk("after_rst_done_cycle", 32'(at_c), 32'd21);
    chk("after_rst_bcd", 32'(bcd), 32'h000007);

    repeat (5) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
